sp_ram_be_clr: RTL and testbench
================================

// Module: sp_ram_be_clr
// PURPOSE
//  Parametrised single-port synchronous RAM with registered request inputs.
//  Adds over the basic RF RAM: byte-enable writes, selectable read-during-write mode,
//  optional output register, read-valid flag and a hardware clear engine.
//  Used as a general scratch/buffer memory behind datapath controllers.
// PARAMETERS
//  AW          5   address width; DEPTH = 2**AW words
//  DW          32  data width; must be a multiple of BW
//  BW          8   byte-lane width; NB = DW/BW lanes
//  RD_MODE     0   read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
//  OUT_REG     1   1 = extra output register stage (+1 cycle latency)
//  CLR_ON_RST  1   1 = clear engine runs automatically after reset release
// PORTS
//  clk       in   1    clock, all logic on rising edge
//  rst       in   1    asynchronous, active-high reset
//  en        in   1    access request; accepted when en=1 and busy=0 at clk edge
//  we        in   1    1 = write, 0 = read (qualified by en)
//  be        in   NB   byte-lane write enables (ignored on reads)
//  addr      in   AW   word address
//  din       in   DW   write data
//  clr       in   1    clear request pulse; sampled only when busy=0
//  busy      out  1    1 while clear engine owns the RAM
//  rd_valid  out  1    1 for one cycle with each read's data on dout
//  dout      out  DW   read data
// BEHAVIOUR
//  Pipeline: S1 input regs (v1,we1,be1,addr1,din1) -> memory access -> [S3 if OUT_REG].
//  Accepted request at edge N is captured in S1; RAM accessed at edge N+1;
//  dout/rd_valid valid after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
//  Write: mem[addr1] lane i <= din1 lane i for each be1[i]=1; other lanes unchanged.
//  dout on access cycle: read -> mem word. write -> READ_FIRST old word,
//   WRITE_FIRST merged new word, NO_CHANGE dout holds. rd_valid=1 only for reads.
//  No access (v1=0): dout holds, rd_valid=0.
//  Requests with en=1 while busy=1 are dropped (no write, no rd_valid).
//  Clear FSM states IDLE, CLEAR; counter cnt [AW-1:0]:
//   IDLE -> CLEAR when clr=1 at edge (cnt<=0); request with en same cycle still accepted.
//   CLEAR: each cycle S1 loaded with write {addr=cnt, be=all 1, din=0}; cnt++.
//   CLEAR -> IDLE on edge that loads cnt=DEPTH-1; busy = (state==CLEAR), exactly DEPTH cycles.
//   clr while busy ignored. Clear writes produce no rd_valid; dout unchanged by them.
//   Request accepted the cycle after busy falls executes after the last clear write.
//  Reset (async, any time incl. mid-clear): v1,we1,S3 valid, rd_valid<=0; dout<=0;
//   cnt<=0; state<=CLEAR if CLR_ON_RST else IDLE (busy=1 during reset when
//   CLR_ON_RST=1). Mid-clear reset restarts clear from address 0.
//   RAM contents not reset; undefined until cleared or written.
//  Back-to-back accesses at full rate, one per cycle, no bubbles.
// TESTING (AW=5, DW=32, BW=8, OUT_REG=1 unless noted)
//  Reset release, CLR_ON_RST=1 -> busy=1 exactly 32 cycles; then read all 32 addrs -> 0, rd_valid each.
//  Write 0xAABBCCDD @3 be=4'hF, then write 0x11223344 @3 be=4'b0101 -> read @3 = 0xAA22CC44, latency 3.
//  Read-during-write @7 (old 0x5, new 0x9): RD_MODE 0 dout=0x5; 1 dout=0x9; 2 dout unchanged; rd_valid=0.
//  clr pulse while back-to-back writes; en during busy -> dropped writes absent, all words 0 after busy falls.
//  Assert rst at clear cnt=10 for 2 cycles -> busy stays 1, clear restarts at addr 0, lasts 32 cycles.
//  OUT_REG=0: read @5 accepted edge N -> dout/rd_valid after edge N+1; continuous reads every cycle.

Source files
------------

// File: rtl/sp_ram_be_clr.sv
// sp_ram_be_clr: single-port synchronous RAM with byte-enable writes,
// selectable read-during-write behaviour, optional output register,
// read-valid flag and a hardware clear engine.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   en/we    - access request (accepted when en=1 and busy=0) / write select
//   be       - byte-lane write enables (NB lanes of BW bits)
//   addr     - word address
//   din      - write data
//   clr      - clear request, sampled only while idle
//   busy     - high while the clear engine owns the RAM
//   rd_valid - one-cycle flag accompanying each read result on dout
//   dout     - read data
module sp_ram_be_clr #(
  parameter  int unsigned AW         = 5,
  parameter  int unsigned DW         = 32,
  parameter  int unsigned BW         = 8,
  parameter  int unsigned RD_MODE    = 0,
  parameter  int unsigned OUT_REG    = 1,
  parameter  int unsigned CLR_ON_RST = 1,
  localparam int unsigned NB         = DW / BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [NB-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic          busy,
  output logic          rd_valid,
  output logic [DW-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // S1 request registers; clr1 marks writes issued by the clear engine
  logic          v1_q, v1_d;
  logic          we1_q, we1_d;
  logic          clr1_q, clr1_d;
  logic [NB-1:0] be1_q, be1_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [DW-1:0] din1_q, din1_d;

  // S3 output-register stage (only meaningful when OUT_REG != 0)
  logic          s3_v_q, s3_v_d;
  logic          s3_upd_q, s3_upd_d;
  logic [DW-1:0] s3_data_q, s3_data_d;

  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] old_word;
  logic [DW-1:0] merged_word;
  logic          acc_rv;
  logic          acc_upd;
  logic [DW-1:0] acc_data;

  assign busy     = (state_q == CLEAR);
  assign rd_valid = rd_valid_q;
  assign dout     = dout_q;

  // Access stage: current word, byte-merged write word and what dout should see
  always_comb begin
    old_word    = mem_q[addr1_q];
    merged_word = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be1_q[i]) merged_word[i*BW +: BW] = din1_q[i*BW +: BW];
    end
    acc_rv   = v1_q && !we1_q;
    // Clear-engine writes and NO_CHANGE writes leave dout alone
    acc_upd  = v1_q && (!we1_q || (!clr1_q && (RD_MODE != 2)));
    acc_data = (v1_q && we1_q && (RD_MODE == 1)) ? merged_word : old_word;
  end

  // Clear FSM and S1 request mux
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v1_d    = en;
    we1_d   = we;
    clr1_d  = 1'b0;
    be1_d   = be;
    addr1_d = addr;
    din1_d  = din;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Engine owns S1; any external request this cycle is dropped
        v1_d    = 1'b1;
        we1_d   = 1'b1;
        clr1_d  = 1'b1;
        be1_d   = '1;
        addr1_d = cnt_q;
        din1_d  = '0;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output path, with or without the extra register stage
  always_comb begin
    s3_v_d    = acc_rv;
    s3_upd_d  = acc_upd;
    s3_data_d = acc_data;
    if (OUT_REG != 0) begin
      rd_valid_d = s3_v_q;
      dout_d     = s3_upd_q ? s3_data_q : dout_q;
    end else begin
      rd_valid_d = acc_rv;
      dout_d     = acc_upd ? acc_data : dout_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      cnt_q      <= '0;
      v1_q       <= 1'b0;
      we1_q      <= 1'b0;
      clr1_q     <= 1'b0;
      be1_q      <= '0;
      addr1_q    <= '0;
      din1_q     <= '0;
      s3_v_q     <= 1'b0;
      s3_upd_q   <= 1'b0;
      s3_data_q  <= '0;
      rd_valid_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      v1_q       <= v1_d;
      we1_q      <= we1_d;
      clr1_q     <= clr1_d;
      be1_q      <= be1_d;
      addr1_q    <= addr1_d;
      din1_q     <= din1_d;
      s3_v_q     <= s3_v_d;
      s3_upd_q   <= s3_upd_d;
      s3_data_q  <= s3_data_d;
      rd_valid_q <= rd_valid_d;
      dout_q     <= dout_d;
    end
  end

  // Storage array; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (v1_q && we1_q) mem_q[addr1_q] <= merged_word;
  end

endmodule

// File: tb/tb_sp_ram_be_clr.sv
module tb_sp_ram_be_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        we;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        clr;

  // Index 0..2: RD_MODE 0/1/2 with OUT_REG=1; index 3: RD_MODE 0 with OUT_REG=0
  logic        busy_w [4];
  logic        rv_w   [4];
  logic [31:0] dout_w [4];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sp_ram_be_clr #(.RD_MODE(0), .OUT_REG(1)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .busy(busy_w[0]), .rd_valid(rv_w[0]), .dout(dout_w[0]));
  sp_ram_be_clr #(.RD_MODE(1), .OUT_REG(1)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .busy(busy_w[1]), .rd_valid(rv_w[1]), .dout(dout_w[1]));
  sp_ram_be_clr #(.RD_MODE(2), .OUT_REG(1)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .busy(busy_w[2]), .rd_valid(rv_w[2]), .dout(dout_w[2]));
  sp_ram_be_clr #(.RD_MODE(0), .OUT_REG(0)) u_o0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .busy(busy_w[3]), .rd_valid(rv_w[3]), .dout(dout_w[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic w, input logic [3:0] b,
                       input logic [4:0] a, input logic [31:0] d, input logic c);
    en = e; we = w; be = b; addr = a; din = d; clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
  endtask

  // Ticks until busy drops, bounded; returns the number of ticks taken
  task automatic wait_busy_fall(output int cycles);
    cycles = 0;
    while (busy_w[0] && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  // Back-to-back application of vecs; OUT_REG=0 result one tick later, OUT_REG=1 two
  task automatic run_vecs(input string tag);
    int n;
    n = vecs.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive(1'b1, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].din, 1'b0);
      else idle();
      tick();
      if (i >= 1) begin
        logic rd;
        rd = (i - 1 < n) && !vecs[i-1].we;
        check($sformatf("%s rd_valid[3] v%0d", tag, i - 1), 32'(rv_w[3]), 32'(rd));
        if (rd) check($sformatf("%s dout[3] v%0d", tag, i - 1), dout_w[3], vecs[i-1].exp);
      end
      if (i >= 2) begin
        logic rd;
        rd = !vecs[i-2].we;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("%s rd_valid[%0d] v%0d", tag, k, i - 2), 32'(rv_w[k]), 32'(rd));
          if (rd) check($sformatf("%s dout[%0d] v%0d", tag, k, i - 2), dout_w[k], vecs[i-2].exp);
        end
      end
    end
    vecs.delete();
  endtask

  task automatic push(input logic w, input logic [3:0] b, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.we = w; v.be = b; v.addr = a; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int cyc;

    rst = 1'b1;
    idle();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset busy[%0d]", k), 32'(busy_w[k]), 32'd1);
      check($sformatf("reset rd_valid[%0d]", k), 32'(rv_w[k]), 32'd0);
      check($sformatf("reset dout[%0d]", k), dout_w[k], 32'h0);
    end
    rst = 1'b0;
    wait_busy_fall(cyc);
    check("power-up clear length", 32'(cyc), 32'd32);
    for (int k = 1; k < 4; k++) check($sformatf("busy low[%0d]", k), 32'(busy_w[k]), 32'd0);

    for (int a = 0; a < 32; a++) push(1'b0, 4'h0, 5'(a), 32'h0, 32'h0);
    run_vecs("clr_rd");

    // Byte-lane merges and mixed back-to-back traffic
    push(1'b1, 4'hF,    5'd3,  32'hAABBCCDD, 32'h0);
    push(1'b1, 4'b0101, 5'd3,  32'h11223344, 32'h0);
    push(1'b0, 4'h0,    5'd3,  32'h0,        32'hAA22CC44);
    push(1'b1, 4'hF,    5'd7,  32'h00000005, 32'h0);
    push(1'b0, 4'h0,    5'd7,  32'h0,        32'h00000005);
    push(1'b1, 4'b1000, 5'd5,  32'hDEADBEEF, 32'h0);
    push(1'b0, 4'h0,    5'd5,  32'h0,        32'hDE000000);
    push(1'b0, 4'h0,    5'd3,  32'h0,        32'hAA22CC44);
    push(1'b1, 4'b0011, 5'd0,  32'h12345678, 32'h0);
    push(1'b0, 4'h0,    5'd0,  32'h0,        32'h00005678);
    push(1'b0, 4'h0,    5'd31, 32'h0,        32'h0);
    run_vecs("main");

    // Read-during-write at address 7 (old 5, new 9), preceded by a read of 5
    drive(1'b1, 1'b0, 4'h0, 5'd5, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'hF, 5'd7, 32'h9, 1'b0);
    tick();
    check("rdw o0 read dout", dout_w[3], 32'hDE000000);
    idle();
    tick();
    check("rdw o0 write dout", dout_w[3], 32'h5);
    check("rdw o0 write rd_valid", 32'(rv_w[3]), 32'd0);
    check("rdw m0 read dout", dout_w[0], 32'hDE000000);
    check("rdw m0 read rd_valid", 32'(rv_w[0]), 32'd1);
    tick();
    check("rdw READ_FIRST dout", dout_w[0], 32'h5);
    check("rdw WRITE_FIRST dout", dout_w[1], 32'h9);
    check("rdw NO_CHANGE dout", dout_w[2], 32'hDE000000);
    for (int k = 0; k < 3; k++) check($sformatf("rdw rd_valid[%0d]", k), 32'(rv_w[k]), 32'd0);

    // Clear raised alongside a write; subsequent requests during busy are dropped
    drive(1'b1, 1'b1, 4'hF, 5'd10, 32'h77, 1'b1);
    tick();
    check("clr busy rise", 32'(busy_w[0]), 32'd1);
    cyc = 0;
    while (busy_w[0] && cyc < 100) begin
      drive(1'b1, 1'b1, 4'hF, 5'(cyc), 32'hF00D0000 | 32'(cyc), 1'b1);
      tick();
      cyc++;
    end
    check("clr length", 32'(cyc), 32'd32);
    check("clr dout[0] held", dout_w[0], 32'h0);
    check("clr dout[1] held", dout_w[1], 32'h77);
    check("clr dout[2] held", dout_w[2], 32'hDE000000);
    check("clr dout[3] held", dout_w[3], 32'h0);
    for (int k = 0; k < 4; k++) check($sformatf("clr rd_valid[%0d]", k), 32'(rv_w[k]), 32'd0);

    // First request after busy falls must land after the final clear write
    push(1'b1, 4'hF, 5'd12, 32'hCAFEBABE, 32'h0);
    for (int a = 0; a < 32; a++) push(1'b0, 4'h0, 5'(a), 32'h0, (a == 12) ? 32'hCAFEBABE : 32'h0);
    run_vecs("post_clr");

    // Reset in the middle of a clear restarts it from address 0
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    check("midclr busy before rst", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("midclr busy in rst", 32'(busy_w[0]), 32'd1);
    check("midclr dout[1] in rst", dout_w[1], 32'h0);
    tick();
    tick();
    check("midclr busy after 2 cycles", 32'(busy_w[0]), 32'd1);
    rst = 1'b0;
    wait_busy_fall(cyc);
    check("midclr restart length", 32'(cyc), 32'd32);

    for (int a = 0; a < 32; a++) push(1'b0, 4'h0, 5'(a), 32'h0, 32'h0);
    run_vecs("final_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
